// File: rtl/sift_frame_sequencer.sv
// Frame sequencer: steers UART bytes into image 1 then image 2, then runs DoG and transmit in turn.
// Optional macro SEQ_TIMEOUT_EN bounds every wait state and adds the sticky ERR state.
module sift_frame_sequencer #(
    parameter int DIMENSION = 64,
    parameter int ADDR_W    = 14,
    parameter int TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wea_img1,
    output logic              wea_img2,
    output logic              dog_start,
    input  logic              dog_busy,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              frame_done,
    output logic [2:0]        state_o,
    output logic [7:0]        drop_cnt,
    output logic              err
);
    localparam int NPIX  = DIMENSION * DIMENSION;
    localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    typedef enum logic [2:0] {
        LOAD_A    = 3'd0,
        LOAD_B    = 3'd1,
        DOG_START = 3'd2,
        DOG_ACK   = 3'd3,
        DOG_RUN   = 3'd4,
        TX_START  = 3'd5,
        TX_WAIT   = 3'd6,
        ERR       = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic              seen_busy_q, seen_busy_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              wea1_q, wea1_d;
    logic              wea2_q, wea2_d;
    logic              in_load;

`ifdef SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
`endif

    assign in_load = (state_q == LOAD_A) || (state_q == LOAD_B);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q     <= LOAD_A;
            pix_cnt_q   <= '0;
            seen_busy_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            drop_cnt_q  <= '0;
            wea1_q      <= 1'b0;
            wea2_q      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            seen_busy_q <= seen_busy_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            drop_cnt_q  <= drop_cnt_d;
            wea1_q      <= wea1_d;
            wea2_q      <= wea2_d;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        seen_busy_d = seen_busy_q;
        unique case (state_q)
            LOAD_A, LOAD_B: begin
                if (rx_valid) begin
                    if (pix_cnt_q == CNT_W'(NPIX - 1)) begin
                        pix_cnt_d = '0;
                        state_d   = (state_q == LOAD_A) ? LOAD_B : DOG_START;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            DOG_START: state_d = DOG_ACK;
            DOG_ACK:   if (dog_busy) state_d = DOG_RUN;
            DOG_RUN:   if (!dog_busy) state_d = TX_START;
            TX_START: begin
                state_d     = TX_WAIT;
                seen_busy_d = 1'b0;
            end
            TX_WAIT: begin
                // Only a busy level seen first counts as completion, so a late-starting tx is not missed.
                if (seen_busy_q && !tx_busy) begin
                    state_d   = LOAD_A;
                    pix_cnt_d = '0;
                end else if (tx_busy) begin
                    seen_busy_d = 1'b1;
                end
            end
            ERR: ;
        endcase
`ifdef SEQ_TIMEOUT_EN
        err_d      = err_q;
        wait_cnt_d = '0;
        if ((state_q == DOG_ACK || state_q == DOG_RUN || state_q == TX_WAIT) && state_d == state_q) begin
            if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                state_d = ERR;
                err_d   = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_comb begin
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wea1_d     = 1'b0;
        wea2_d     = 1'b0;
        drop_cnt_d = drop_cnt_q;
        if (rx_valid) begin
            if (in_load) begin
                wr_addr_d = ADDR_W'(pix_cnt_q);
                wr_data_d = rx_data;
                wea1_d    = (state_q == LOAD_A);
                wea2_d    = (state_q == LOAD_B);
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    // Start pulses are suppressed while reset is held so an aborted frame never launches a stage.
    always_comb begin
        dog_start  = (state_q == DOG_START) && !rst_in;
        tx_start   = (state_q == TX_START) && !rst_in;
        frame_done = (state_q == TX_WAIT) && seen_busy_q && !tx_busy && !rst_in;
        state_o    = state_q;
    end

    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wea_img1 = wea1_q;
    assign wea_img2 = wea2_q;
    assign drop_cnt = drop_cnt_q;
`ifdef SEQ_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/sift_frame_sequencer.md
Name: sift_frame_sequencer

Overview:
- Automatic controller for the receive -> DoG -> transmit image path.
- Removes the manual switch and button sequencing from the flow.
- Steers UART bytes into the sharper-image BRAM (image 1), then the fuzzier-image BRAM (image 2).
- Then pulses the DoG builder start, waits for it to finish, pulses the image transmitter start, waits for that to finish, and re-arms for the next frame pair.
- Sits in top_level between uart_rx, the two image BRAMs' port A, dog, and send_img.

Parameters:
- DIMENSION, 64, image side length in pixels; one image is DIMENSION*DIMENSION bytes.
- ADDR_W, 14, width of BRAM port-A address; pixel index is zero-extended to this width.
- TIMEOUT, 1000000, max cycles allowed in any wait state (used only with SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock (100 MHz)
- rst_in  in  1  synchronous active-high reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received greyscale byte
- wr_addr  out  ADDR_W  image BRAM port-A address
- wr_data  out  8  image BRAM port-A write data
- wea_img1  out  1  write enable, sharper-image BRAM
- wea_img2  out  1  write enable, fuzzier-image BRAM
- dog_start  out  1  one-cycle start pulse to dog (drives its bram_ready)
- dog_busy  in  1  dog busy level
- tx_start  out  1  one-cycle start pulse to send_img (drives img_ready)
- tx_busy  in  1  send_img busy level
- frame_done  out  1  one-cycle pulse when a full frame cycle completes
- state_o  out  3  current state encoding, for LEDs
- drop_cnt  out  8  saturating count of bytes dropped outside load states
- err  out  1  sticky timeout flag (always 0 without SEQ_TIMEOUT_EN)

Behaviour:
- Reset: state=LOAD_A, pixel counter=0, drop_cnt=0, err=0. All outputs 0 (wr_addr=0, wr_data=0).
- Reset mid-operation aborts immediately. No start pulse is emitted in the reset cycle. Partial BRAM contents are simply overwritten on reload.
- States and state_o encodings:
  - LOAD_A=0, LOAD_B=1, DOG_START=2, DOG_ACK=3, DOG_RUN=4, TX_START=5, TX_WAIT=6, ERR=7.
  - TX_WAIT covers both ack and run via an internal seen_busy bit.
- Byte write timing, rx_valid at cycle t in LOAD_A or LOAD_B with counter=k:
  - At t+1: wr_addr=k, wr_data=rx_data(t), and exactly one of wea_img1 (LOAD_A) or wea_img2 (LOAD_B) is high for exactly one cycle.
  - Counter increments.
  - If k==DIMENSION*DIMENSION-1: counter wraps to 0 and state advances (LOAD_A->LOAD_B, LOAD_B->DOG_START) at t+1.
- rx_valid in any other state:
  - Byte is ignored; no write enable asserts.
  - drop_cnt increments, saturating at 255.
  - drop_cnt is cleared only by rst_in.
- DOG_START:
  - dog_start=1 for this single cycle only, then go to DOG_ACK.
  - If the last byte arrived at t, dog_start is high at t+1, concurrent with the final wea_img2.
- DOG_ACK: wait for dog_busy=1, then go to DOG_RUN.
- DOG_RUN: wait for dog_busy=0, then go to TX_START.
- Busy already high on the DOG_START cycle is accepted: DOG_ACK passes on its first cycle.
- TX_START: tx_start=1 for one cycle, then go to TX_WAIT.
- TX_WAIT:
  - Set seen_busy when tx_busy=1.
  - When seen_busy and tx_busy=0: frame_done=1 for that cycle, then go to LOAD_A with counter=0.
- Bytes may arrive on the same cycle that TX_WAIT exits. Such a byte is dropped, because the state is not yet LOAD_A.
- The start outputs and write enables are never high simultaneously, except for the final wea_img2 with dog_start described above.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- When defined:
  - A wait counter resets on entry to DOG_ACK, DOG_RUN and TX_WAIT, and increments each cycle in those states.
  - On reaching TIMEOUT: go to ERR and set err=1.
  - ERR ignores all inputs except rst_in; rx bytes are counted in drop_cnt.
- When not defined:
  - No counter is built; wait states wait indefinitely.
  - err is tied to 0 and ERR is unreachable.

Test Plan:
- DIMENSION=4: send 32 bytes 0..31 -> wea_img1 pulses with addr 0..15, data 0..15; then wea_img2 with addr 0..15, data 16..31; dog_start high the cycle after the last byte.
- After dog_start, dog_busy high for 50 cycles then low -> state 3->4->5; tx_start one pulse; tx_busy high 20 cycles then low -> frame_done pulse; state_o=0.
- 3 bytes injected during DOG_RUN -> no write enables, drop_cnt=3; 300 bytes injected -> drop_cnt=255.
- rst_in asserted after 7 bytes of image A -> all outputs 0; the next byte writes wr_addr=0 via wea_img1.
- dog_busy never asserts, TIMEOUT=100, SEQ_TIMEOUT_EN defined -> state_o=7, err=1 after 100 cycles in DOG_ACK. Without the macro -> remains in state 3 indefinitely, err=0.
- Two back-to-back full frames -> second frame writes start at wr_addr=0 in image 1; exactly two dog_start, two tx_start and two frame_done pulses.
